// File: rtl/seg_display_ctrl_if.sv
// Bus bundle for the seven-segment display controller: load request,
// display options and the status/segment outputs.
interface seg_display_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
);
  logic [WIDTH-1:0]    din;
  logic                dval;
  logic                hex_mode;
  logic                lz_blank;
  logic                enable;
  logic [7*DIGITS-1:0] seg;
  logic                busy;
  logic                done;
  logic                ovf;

  // Driver side (SoC / instruction-pointer source)
  modport master (
    output din, dval, hex_mode, lz_blank, enable,
    input  seg, busy, done, ovf
  );

  // Controller side
  modport slave (
    input  din, dval, hex_mode, lz_blank, enable,
    output seg, busy, done, ovf
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller. Converts a WIDTH-bit value to signed or
// unsigned decimal (sequential double-dabble, one bit per clock) or to hex,
// with leading-zero blanking, overflow dashes and a one-deep pending request.
module seg_display_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              resetn,
  seg_display_ctrl_if.slave bus
);

  // Each 3 bits of binary add at most one decimal digit, so this BCD width
  // always holds the full magnitude and overflow detection stays exact.
  localparam int BD  = WIDTH / 3 + 1;
  localparam int H   = (WIDTH + 3) / 4;
  localparam int NS0 = (BD > H) ? BD : H;
  localparam int NS  = (NS0 > DIGITS) ? NS0 : DIGITS;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      4'hF:    hex_to_seg = 7'h0E;
      default: hex_to_seg = 7'h7F;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*BD-1:0]     bcd_q, bcd_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic                neg_q, neg_d;
  logic                hex_q, hex_d;
  logic                lz_q, lz_d;
  logic                pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0]    pend_din_q, pend_din_d;
  logic                pend_hex_q, pend_hex_d;
  logic                pend_lz_q, pend_lz_d;
  logic [7*DIGITS-1:0] disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [WIDTH-1:0]    req_din_s;
  logic                req_hex_s;
  logic                req_lz_s;
  logic                neg_s;
  logic [WIDTH-1:0]    mag_s;
  logic [4*BD-1:0]     adj_s;
  logic [4*BD-1:0]     bcd_sh_s;
  logic [WIDTH-1:0]    bin_sh_s;
  logic [4*NS-1:0]     src_s;
  int                  msd_s;
  int                  lim_s;
  logic                ovf_fmt_s;
  logic [7*DIGITS-1:0] disp_fmt_s;

  // Select the request to capture (pending slot wins) and form its magnitude
  always_comb begin
    if (pend_vld_q) begin
      req_din_s = pend_din_q;
      req_hex_s = pend_hex_q;
      req_lz_s  = pend_lz_q;
    end else begin
      req_din_s = bus.din;
      req_hex_s = bus.hex_mode;
      req_lz_s  = bus.lz_blank;
    end
    neg_s = (SIGNED != 0) && !req_hex_s && req_din_s[WIDTH-1];
    if (neg_s) begin
      mag_s = (~req_din_s) + WIDTH'(1);
    end else begin
      mag_s = req_din_s;
    end
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift left
  always_comb begin
    adj_s = bcd_q;
    for (int i = 0; i < BD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
    {bcd_sh_s, bin_sh_s} = {adj_s, bin_q} << 1;
  end

  // Lay out the finished result as segment codes and detect overflow
  always_comb begin
    src_s = '0;
    if (hex_q) begin
      src_s[WIDTH-1:0] = bin_q;
      lim_s            = H;
    end else begin
      src_s[4*BD-1:0] = bcd_q;
      lim_s           = DIGITS;
    end
    msd_s = 0;
    for (int i = 0; i < NS; i++) begin
      if (src_s[4*i +: 4] != 4'd0) begin
        msd_s = i;
      end else begin
        msd_s = msd_s;
      end
    end
    if (hex_q) begin
      ovf_fmt_s = (H > DIGITS);
    end else begin
      ovf_fmt_s = ((msd_s + 1) > (neg_q ? DIGITS - 1 : DIGITS));
    end
    disp_fmt_s = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (ovf_fmt_s) begin
        disp_fmt_s[7*k +: 7] = SEG_DASH;
      end else if (neg_q && !lz_q && (k == DIGITS - 1)) begin
        disp_fmt_s[7*k +: 7] = SEG_DASH;
      end else if ((k < lim_s) && (!lz_q || (k <= msd_s))) begin
        disp_fmt_s[7*k +: 7] = hex_to_seg(src_s[4*k +: 4]);
      end else if (neg_q && lz_q && (k == msd_s + 1)) begin
        disp_fmt_s[7*k +: 7] = SEG_DASH;
      end else begin
        disp_fmt_s[7*k +: 7] = SEG_BLANK;
      end
    end
  end

  // Conversion FSM next state, datapath loads and pending-slot bookkeeping
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    neg_d      = neg_q;
    hex_d      = hex_q;
    lz_d       = lz_q;
    pend_vld_d = pend_vld_q;
    pend_din_d = pend_din_q;
    pend_hex_d = pend_hex_q;
    pend_lz_d  = pend_lz_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q || bus.dval) begin
          bin_d   = req_hex_s ? req_din_s : mag_s;
          bcd_d   = '0;
          neg_d   = neg_s;
          hex_d   = req_hex_s;
          lz_d    = req_lz_s;
          cnt_d   = '0;
          state_d = req_hex_s ? ST_COMMIT : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        bcd_d = bcd_sh_s;
        bin_d = bin_sh_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        disp_d  = disp_fmt_s;
        ovf_d   = ovf_fmt_s;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A request that cannot be captured this cycle replaces the pending one;
    // a pending request consumed in IDLE frees the slot.
    if (bus.dval && ((state_q != ST_IDLE) || pend_vld_q)) begin
      pend_vld_d = 1'b1;
      pend_din_d = bus.din;
      pend_hex_d = bus.hex_mode;
      pend_lz_d  = bus.lz_blank;
    end else if ((state_q == ST_IDLE) && pend_vld_q) begin
      pend_vld_d = 1'b0;
    end else begin
      pend_vld_d = pend_vld_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bcd_q      <= '0;
      bin_q      <= '0;
      neg_q      <= 1'b0;
      hex_q      <= 1'b0;
      lz_q       <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_din_q <= '0;
      pend_hex_q <= 1'b0;
      pend_lz_q  <= 1'b0;
      disp_q     <= '1;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      neg_q      <= neg_d;
      hex_q      <= hex_d;
      lz_q       <= lz_d;
      pend_vld_q <= pend_vld_d;
      pend_din_q <= pend_din_d;
      pend_hex_q <= pend_hex_d;
      pend_lz_q  <= pend_lz_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // enable gates the stored display straight at the pins
  assign bus.seg  = bus.enable ? disp_q : {(7*DIGITS){1'b1}};
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed self-checking bench for seg_display_ctrl: default 8-bit/4-digit
// signed instance plus two 2-digit instances for overflow cases.
module tb_seg_display_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  localparam logic [27:0] A_BLANK = {4{7'h7F}};
  localparam logic [13:0] BC_DASH = {7'h3F, 7'h3F};

  always #5 clk = ~clk;

  seg_display_ctrl_if #(.WIDTH(8), .DIGITS(4)) ifa ();
  seg_display_ctrl_if #(.WIDTH(8), .DIGITS(2)) ifb ();
  seg_display_ctrl_if #(.WIDTH(8), .DIGITS(2)) ifc ();

  seg_display_ctrl #(.WIDTH(8), .DIGITS(4), .SIGNED(1)) dut_a (
    .clk(clk), .resetn(resetn), .bus(ifa)
  );
  seg_display_ctrl #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) dut_b (
    .clk(clk), .resetn(resetn), .bus(ifb)
  );
  seg_display_ctrl #(.WIDTH(8), .DIGITS(2), .SIGNED(1)) dut_c (
    .clk(clk), .resetn(resetn), .bus(ifc)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One request on dut_a, bounded wait for done, check latency/segments/ovf
  task automatic do_a(input logic [7:0] d, input logic h, input logic lz,
                      input logic [27:0] exp, input string tag);
    int n;
    @(negedge clk);
    ifa.din = d; ifa.hex_mode = h; ifa.lz_blank = lz; ifa.dval = 1'b1;
    @(negedge clk);
    ifa.dval = 1'b0;
    n = 0;
    while (!ifa.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done"}, ifa.done, 1);
    check_val({tag, "_lat"}, n, h ? 1 : 9);
    check_val({tag, "_seg"}, ifa.seg, exp);
    check_val({tag, "_ovf"}, ifa.ovf, 0);
  endtask

  // Same request to both 2-digit instances
  task automatic do_bc(input logic [7:0] d, input logic ovb, input logic [13:0] sb,
                       input logic ovc, input logic [13:0] sc, input string tag);
    int n;
    @(negedge clk);
    ifb.din = d; ifb.dval = 1'b1;
    ifc.din = d; ifc.dval = 1'b1;
    @(negedge clk);
    ifb.dval = 1'b0; ifc.dval = 1'b0;
    n = 0;
    while (!ifb.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_b_done"}, ifb.done, 1);
    check_val({tag, "_c_done"}, ifc.done, 1);
    check_val({tag, "_b_ovf"}, ifb.ovf, ovb);
    check_val({tag, "_b_seg"}, ifb.seg, sb);
    check_val({tag, "_c_ovf"}, ifc.ovf, ovc);
    check_val({tag, "_c_seg"}, ifc.seg, sc);
  endtask

  initial begin
    int dones;
    int first_at;
    int second_at;
    logic saw_nine;

    ifa.din = '0; ifa.dval = 1'b0; ifa.hex_mode = 1'b0; ifa.lz_blank = 1'b1; ifa.enable = 1'b1;
    ifb.din = '0; ifb.dval = 1'b0; ifb.hex_mode = 1'b0; ifb.lz_blank = 1'b1; ifb.enable = 1'b1;
    ifc.din = '0; ifc.dval = 1'b0; ifc.hex_mode = 1'b0; ifc.lz_blank = 1'b1; ifc.enable = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check_val("rst_seg_a", ifa.seg, A_BLANK);
    check_val("rst_busy_a", ifa.busy, 0);
    check_val("rst_done_a", ifa.done, 0);
    check_val("rst_ovf_a", ifa.ovf, 0);
    check_val("rst_seg_b", ifb.seg, {2{7'h7F}});
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // test 1: 127 decimal, blanked, full timing
    ifa.din = 8'h7F; ifa.hex_mode = 1'b0; ifa.lz_blank = 1'b1; ifa.dval = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      ifa.dval = 1'b0;
      check_val($sformatf("t1_busy_%0d", i), ifa.busy, 1);
      check_val($sformatf("t1_done_%0d", i), ifa.done, 0);
      if (i == 5) check_val("t1_hold_seg", ifa.seg, A_BLANK);
    end
    @(negedge clk);
    check_val("t1_seg", ifa.seg, {7'h7F, 7'h79, 7'h24, 7'h78});
    check_val("t1_done", ifa.done, 1);
    check_val("t1_ovf", ifa.ovf, 0);
    check_val("t1_busy_end", ifa.busy, 0);
    @(negedge clk);
    check_val("t1_done_pulse", ifa.done, 0);

    // test 2: signed extremes
    do_a(8'h80, 1'b0, 1'b1, {7'h3F, 7'h79, 7'h24, 7'h00}, "t2_m128");
    do_a(8'hF6, 1'b0, 1'b1, {7'h7F, 7'h3F, 7'h79, 7'h40}, "t2_m10_lz");
    do_a(8'hF6, 1'b0, 1'b0, {7'h3F, 7'h40, 7'h79, 7'h40}, "t2_m10_nolz");
    do_a(8'h00, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, "t2_zero");

    // test 3: hex mode and enable gating
    do_a(8'h05, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, "t3_hex05_lz");
    do_a(8'h05, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h40, 7'h12}, "t3_hex05_nolz");
    do_a(8'hA5, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h08, 7'h12}, "t3_hexA5");
    ifa.enable = 1'b0;
    #1 check_val("t3_en_off", ifa.seg, A_BLANK);
    @(negedge clk);
    check_val("t3_en_off_hold", ifa.seg, A_BLANK);
    ifa.enable = 1'b1;
    #1 check_val("t3_en_on", ifa.seg, {7'h7F, 7'h7F, 7'h08, 7'h12});

    // test 4: back-to-back requests through the pending slot
    @(negedge clk);
    ifa.hex_mode = 1'b0; ifa.lz_blank = 1'b1;
    ifa.din = 8'd5; ifa.dval = 1'b1;
    dones = 0; first_at = -1; second_at = -1; saw_nine = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (ifa.done) begin
        dones++;
        if (first_at < 0) begin
          first_at = i;
          check_val("t4_first_seg", ifa.seg, {7'h7F, 7'h7F, 7'h7F, 7'h12});
        end else begin
          second_at = i;
          check_val("t4_second_seg", ifa.seg, {7'h7F, 7'h7F, 7'h7F, 7'h30});
        end
      end
      if (ifa.seg[6:0] == 7'h10) saw_nine = 1'b1;
      if (i == 10) check_val("t4_idle_gap", ifa.busy, 0);
      if (i == 11) check_val("t4_recapture", ifa.busy, 1);
      case (i)
        1, 3, 6: ifa.dval = 1'b0;
        2: begin ifa.din = 8'd9; ifa.dval = 1'b1; end
        5: begin ifa.din = 8'd3; ifa.dval = 1'b1; end
        default: ;
      endcase
    end
    check_val("t4_dones", dones, 2);
    check_val("t4_first_at", first_at, 10);
    check_val("t4_second_at", second_at, 20);
    check_val("t4_no_nine", saw_nine, 0);

    // test 5: overflow on 2-digit instances, then clear
    do_bc(8'd100, 1'b1, BC_DASH, 1'b1, BC_DASH, "t5_100");
    do_bc(8'hF6, 1'b1, BC_DASH, 1'b1, BC_DASH, "t5_F6");
    do_bc(8'd42, 1'b0, {7'h19, 7'h24}, 1'b0, {7'h19, 7'h24}, "t5_42");

    // test 6: reset during SHIFT with a pending request
    @(negedge clk);
    ifa.din = 8'h7F; ifa.dval = 1'b1;
    @(negedge clk);
    ifa.dval = 1'b0;
    @(negedge clk);
    ifa.din = 8'h05; ifa.dval = 1'b1;
    @(negedge clk);
    ifa.dval = 1'b0;
    check_val("t6_busy_before", ifa.busy, 1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_val("t6_seg", ifa.seg, A_BLANK);
    check_val("t6_busy", ifa.busy, 0);
    check_val("t6_done", ifa.done, 0);
    check_val("t6_ovf_b", ifb.ovf, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifa.done || ifa.busy) dones++;
    end
    check_val("t6_no_commit", dones, 0);
    check_val("t6_seg_after", ifa.seg, A_BLANK);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Parametrised seven-segment display controller for any DE-series HEX bank. It converts a WIDTH-bit value to decimal or hexadecimal, and is driven either by the SoC data output or by the instruction pointer. The binary-to-BCD conversion is sequential, one bit per clock, and has a valid/busy handshake with a one-deep pending slot. Signed decimal, leading-zero blanking, overflow indication and a runtime hex/decimal mode select are all supported.

## Interface
- WIDTH, 8: input data width, minimum 4.
- DIGITS, 4: number of seven-segment digits driven, minimum 2.
- SIGNED, 1: if 1, decimal-mode din is two's complement.
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- din  in  WIDTH  value to display.
- dval  in  1  load strobe; din, hex_mode and lz_blank are sampled together with it.
- hex_mode  in  1  1 = hexadecimal display, 0 = decimal display.
- lz_blank  in  1  1 = blank leading zeros.
- enable  in  1  0 = all digits blank; the stored result is retained.
- seg  out  7*DIGITS  active-low segments; digit k is seg[7k+6:7k], bit 0 = a … bit 6 = g.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when seg is updated.
- ovf  out  1  result did not fit in DIGITS; held until the next commit.

## Operation
- Segment codes, 0–F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex). Dash = 3F. Blank = 7F.
- States:
  - IDLE: on a capture go to SHIFT in decimal mode, or to COMMIT in hex mode.
  - SHIFT: runs exactly WIDTH cycles of double-dabble (add-3 to each nibble ≥5, then shift left 1), then goes to COMMIT.
  - COMMIT: writes the display register, pulses done, returns to IDLE.
- Capture: occurs in IDLE when dval=1 or the pending slot is valid. The pending slot has priority, and is cleared when used.
- dval while busy, including in the COMMIT cycle: {din, hex_mode, lz_blank} goes into the pending slot, overwriting any earlier pending value. Only the latest request is kept.
- Signed decimal (SIGNED=1, hex_mode=0):
  - neg = din[WIDTH-1]; magnitude = two's-complement absolute value, held in WIDTH unsigned bits.
  - -2^(WIDTH-1) must convert correctly.
- Decimal layout:
  - The magnitude is right-aligned in the low digits.
  - lz_blank=1: zeros above the most significant nonzero digit are blank, but the value 0 still shows a single "0". If neg, the dash goes in the digit just left of the most significant shown digit.
  - lz_blank=0: all magnitude digits are shown. If neg, the dash goes in digit DIGITS-1 and the magnitude gets DIGITS-1 digits.
- Decimal overflow occurs when the magnitude needs more than DIGITS digits, or more than DIGITS-1 digits when neg. Overflow detection must be exact; the internal BCD register is sized so that it never truncates. On overflow, ovf=1 and every digit shows dash.
- Hex mode:
  - No sign is shown.
  - H = ceil(WIDTH/4) nibbles, right-aligned; digits above H are blank.
  - lz_blank applies as in decimal.
  - H > DIGITS gives overflow with all digits dash.
- The display register is updated only in COMMIT, so the previous value stays shown during a conversion.
- seg = enable ? display register : all 7F.

## Timing
- Reset: seg all 7F, busy=0, done=0, ovf=0, pending slot cleared, state IDLE. Reset takes effect immediately, even mid-SHIFT; the in-flight conversion is discarded.
- Capture edge E:
  - Decimal mode: the COMMIT edge is E+WIDTH+1. seg, ovf and done change at that edge.
  - Hex mode: the COMMIT edge is E+1.
- busy is 1 from edge E until the COMMIT edge, and 0 in the cycle after COMMIT.
- done is high for exactly one cycle, the cycle after the COMMIT edge.
- Pending slot valid at COMMIT: the next capture is at COMMIT+1, so there is one IDLE cycle.
- seg is registered. enable is applied combinationally at the output, so a change on enable is visible with zero latency.
- Throughput: one decimal result per WIDTH+2 cycles.

## Test plan
Default parameters unless stated. Digits are listed 3..0.
1. Decimal, lz_blank=1, din=7F pulsed at edge E -> at E+9: seg = 7F,79,24,78; done high for one cycle; ovf=0; busy high during E..E+8.
2. Signed extremes:
   - din=80 -> 3F,79,24,00 (-128).
   - din=F6 with lz_blank=1 -> 7F,3F,79,40.
   - din=F6 with lz_blank=0 -> 3F,40,79,40.
   - din=00 with lz_blank=1 -> 7F,7F,7F,40.
3. hex_mode=1, din=A5 at edge E -> at E+1 (COMMIT) seg = 7F,7F,08,12. Pulse enable=0 -> all 7F with the result retained; enable=1 restores it.
4. Back-to-back requests:
   - Send dval 5, then dval 9 two cycles later, then dval 3 three cycles later.
   - Required: the first commit shows 5; a capture follows one cycle after commit and shows 3; 9 is never displayed; exactly two done pulses.
5. Overflow:
   - DIGITS=2, SIGNED=0, din=100 -> ovf=1, seg=3F,3F.
   - DIGITS=2, SIGNED=1, din=F6 -> ovf=1.
   - A following din=42 clears ovf and shows 19,24.
6. Reset mid-SHIFT, with resetn low at E+4 -> immediately seg all 7F, busy=0, done=0, pending cleared; no commit occurs after release.
